// File: rtl/bytebeat_sample_scheduler_if.sv
// bytebeat_sample_scheduler_if: voice sample handshake bus between voice cores and the frame scheduler
interface bytebeat_sample_scheduler_if #(parameter int NUM_VOICES = 8);
  logic [NUM_VOICES-1:0]   voice_vld;
  logic [NUM_VOICES-1:0]   voice_rdy;
  logic [8*NUM_VOICES-1:0] voice_pcm;
  modport master (output voice_vld, voice_pcm, input voice_rdy);
  modport slave (input voice_vld, voice_pcm, output voice_rdy);
endinterface

// File: rtl/bytebeat_sample_scheduler.sv
// bytebeat_sample_scheduler: frame scheduler collecting one sample per voice per frame and publishing a mean mix
// BYTEBEAT_SCHED_SOLO_EN adds solo_en_i/solo_sel_i to replace the mean with one held sample
module bytebeat_sample_scheduler #(
  parameter int NUM_VOICES = 8,
  parameter int DIV_W      = 12,
  parameter int TIMEOUT    = 63
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DIV_W-1:0]           div_cfg_i,
  input  logic [NUM_VOICES-1:0]      voice_en_i,
  bytebeat_sample_scheduler_if.slave voice_if,
  output logic [8*NUM_VOICES-1:0]    sample_out_o,
  output logic [7:0]                 mix_out_o,
  output logic                       mix_vld_o,
  output logic [NUM_VOICES-1:0]      miss_o,
  output logic                       overrun_o,
  input  logic                       clr_err_i
`ifdef BYTEBEAT_SCHED_SOLO_EN
  ,
  input  logic                       solo_en_i,
  input  logic [$clog2(NUM_VOICES)-1:0] solo_sel_i
`endif
);
  localparam int IW = $clog2(NUM_VOICES);
  localparam int TW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t                        state_q;
  logic [DIV_W-1:0]              cnt_q;
  logic [IW-1:0]                 idx_q;
  logic [TW-1:0]                 wait_q;
  logic [NUM_VOICES-1:0][7:0]    smp_q;
  logic [7:0]                    mix_q, mix_d;
  logic                          mix_vld_q, ovr_q;
  logic [NUM_VOICES-1:0]         miss_q, onehot;
  logic [7+IW:0]                 sum;
  logic                          tick, en, vld, act, fire, tmo, adv, last;
  assign tick   = cnt_q == '0;
  assign en     = voice_en_i[idx_q];
  assign vld    = voice_if.voice_vld[idx_q];
  assign act    = state_q == REQ && en;
  assign fire   = act && vld;
  assign tmo    = act && !vld && wait_q == TW'(TIMEOUT);
  assign adv    = state_q == REQ && (!en || fire || tmo);
  assign last   = idx_q == IW'(NUM_VOICES - 1);
  assign onehot = {{(NUM_VOICES-1){1'b0}}, 1'b1} << idx_q;
  // rdy is gated by rst_n so an asserted reset drops it before the clock edge
  assign voice_if.voice_rdy = (act && rst_n) ? onehot : '0;
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) sum = sum + {{IW{1'b0}}, smp_q[i]};
  end
`ifdef BYTEBEAT_SCHED_SOLO_EN
  assign mix_d = solo_en_i ? smp_q[solo_sel_i] : sum[7+IW:IW];
`else
  assign mix_d = sum[7+IW:IW];
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= div_cfg_i;
      idx_q     <= '0;
      wait_q    <= '0;
      smp_q     <= {NUM_VOICES{8'h80}};
      mix_q     <= 8'h80;
      mix_vld_q <= 1'b0;
      miss_q    <= '0;
      ovr_q     <= 1'b0;
    end else begin
      cnt_q     <= tick ? div_cfg_i : cnt_q - 1'b1;
      mix_vld_q <= state_q == DONE;
      miss_q    <= (clr_err_i ? '0 : miss_q) | (tmo ? onehot : '0);
      ovr_q     <= (clr_err_i ? 1'b0 : ovr_q) | (tick && state_q != IDLE);
      wait_q    <= (act && !adv) ? wait_q + 1'b1 : '0;
      if (fire) smp_q[idx_q] <= voice_if.voice_pcm[idx_q*8 +: 8];
      if (state_q == REQ && !en) smp_q[idx_q] <= 8'h80;
      case (state_q)
        IDLE: if (tick) begin
          state_q <= REQ;
          idx_q   <= '0;
        end
        REQ: if (adv) begin
          idx_q <= idx_q + 1'b1;
          if (last) state_q <= DONE;
        end
        DONE: begin
          mix_q   <= mix_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign sample_out_o = smp_q;
  assign mix_out_o    = mix_q;
  assign mix_vld_o    = mix_vld_q;
  assign miss_o       = miss_q;
  assign overrun_o    = ovr_q;
endmodule
